// File: rtl/ts_pkg.sv
// Shared definitions for the MPEG transport-stream continuity monitor.
// Holds the TS framing constants, the per-channel sync FSM state type and
// a small helper for modulo-16 continuity-counter arithmetic.
package ts_pkg;

  localparam logic [7:0]  SYNC_BYTE = 8'h47;
  localparam int          PKT_LEN   = 188;
  localparam logic [12:0] NULL_PID  = 13'h1FFF;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } ts_state_e;

  // Expected continuity counter of the next packet (wraps 15 -> 0).
  function automatic logic [3:0] cc_succ(input logic [3:0] cc);
    return cc + 4'd1;
  endfunction

endpackage

// File: rtl/ts_ch_monitor.sv
// One TS byte channel: sync acquisition (HUNT/CONFIRM/LOCKED), header
// parsing, continuity-counter checking and saturating statistics.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   byte_data/valid     incoming byte and its qualifier
//   pid_filter          PID whose continuity is checked
//   clr                 clears counters and CC history, keeps lock state
//   locked              high while the FSM is in LOCKED
//   cc_err              one-cycle pulse after an erroneous header byte
//   pkt_cnt, cc_err_cnt, sync_loss_cnt  saturating counters
module ts_ch_monitor
  import ts_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int LOCK_N   = 3,
  parameter int UNLOCK_N = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  input  logic [12:0]      pid_filter,
  input  logic             clr,
  output logic             locked,
  output logic             cc_err,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] cc_err_cnt,
  output logic [CNT_W-1:0] sync_loss_cnt
);

  localparam logic [7:0]       LOCK_T   = 8'(LOCK_N);
  localparam logic [7:0]       UNLOCK_T = 8'(UNLOCK_N);
  localparam logic [7:0]       LAST_POS = 8'(PKT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  ts_state_e        state_reg, state_next;
  logic [7:0]       pos_reg, pos_next;
  logic [7:0]       good_reg, good_next;
  logic [7:0]       miss_reg, miss_next;
  logic [4:0]       pid_hi_reg, pid_hi_next;
  logic [7:0]       pid_lo_reg, pid_lo_next;
  logic [12:0]      filt_reg;
  logic             hist_reg, hist_next;     // last_cc_reg holds a valid CC
  logic             dup_reg, dup_next;       // previous checked packet was a duplicate
  logic [3:0]       last_cc_reg, last_cc_next;
  logic             cc_err_reg, cc_err_next;
  logic [CNT_W-1:0] pkt_reg, pkt_next;
  logic [CNT_W-1:0] err_reg, err_next;
  logic [CNT_W-1:0] loss_reg, loss_next;
  logic             cc_bad, loss_inc;

  logic        is_sync, hdr3, checked, hist_ok;
  logic [12:0] pid;
  logic [3:0]  rx_cc;
  logic [1:0]  rx_afc;

  assign is_sync = (byte_data == SYNC_BYTE);
  assign pid     = {pid_hi_reg, pid_lo_reg};
  assign rx_afc  = byte_data[5:4];
  assign rx_cc   = byte_data[3:0];
  assign hdr3    = byte_valid && (state_reg == LOCKED) && (pos_reg == 8'd3);
  assign checked = hdr3 && (pid == pid_filter) && (pid != NULL_PID);
  // A filter change invalidates the stored CC in the very cycle it happens.
  assign hist_ok = hist_reg && (pid_filter == filt_reg);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    state_next   = state_reg;
    pos_next     = pos_reg;
    good_next    = good_reg;
    miss_next    = miss_reg;
    pid_hi_next  = pid_hi_reg;
    pid_lo_next  = pid_lo_reg;
    hist_next    = hist_ok;
    dup_next     = dup_reg;
    last_cc_next = last_cc_reg;
    cc_bad       = 1'b0;
    loss_inc     = 1'b0;

    if (byte_valid) begin
      pos_next = (pos_reg == LAST_POS) ? 8'd0 : pos_reg + 8'd1;
      unique case (state_reg)
        HUNT: begin
          if (is_sync) begin
            pos_next   = 8'd1;
            good_next  = 8'd1;
            miss_next  = 8'd0;
            state_next = (LOCK_T <= 8'd1) ? LOCKED : CONFIRM;
          end else begin
            pos_next = 8'd0;
          end
        end
        CONFIRM: begin
          if (pos_reg == 8'd0) begin
            if (is_sync) begin
              good_next = good_reg + 8'd1;
              if (good_reg + 8'd1 >= LOCK_T) begin
                state_next = LOCKED;
                miss_next  = 8'd0;
              end
            end else begin
              state_next = HUNT;
              pos_next   = 8'd0;
              good_next  = 8'd0;
            end
          end
        end
        LOCKED: begin
          if (pos_reg == 8'd0) begin
            if (is_sync) begin
              miss_next = 8'd0;
            end else if (miss_reg + 8'd1 >= UNLOCK_T) begin
              state_next = HUNT;
              pos_next   = 8'd0;
              good_next  = 8'd0;
              miss_next  = 8'd0;
              hist_next  = 1'b0;
              loss_inc   = 1'b1;
            end else begin
              miss_next = miss_reg + 8'd1;
            end
          end
          if (pos_reg == 8'd1) pid_hi_next = byte_data[4:0];
          if (pos_reg == 8'd2) pid_lo_next = byte_data;
        end
        default: state_next = HUNT;
      endcase
    end

    // Continuity check on the fourth header byte of a monitored packet.
    if (checked) begin
      last_cc_next = rx_cc;
      hist_next    = 1'b1;
      dup_next     = 1'b0;
      if (hist_ok) begin
        if (rx_afc[0]) begin
          // Payload present: CC must advance, one repeat is tolerated.
          if (rx_cc == cc_succ(last_cc_reg)) begin
            dup_next = 1'b0;
          end else if (rx_cc == last_cc_reg) begin
            cc_bad   = dup_reg;
            dup_next = 1'b1;
          end else begin
            cc_bad = 1'b1;
          end
        end else begin
          // No payload: CC must not change.
          cc_bad = (rx_cc != last_cc_reg);
        end
      end
    end

    if (clr) hist_next = 1'b0;

    cc_err_next = cc_bad;
    pkt_next    = clr ? '0 : sat_inc(pkt_reg, hdr3);
    err_next    = clr ? '0 : sat_inc(err_reg, cc_bad);
    loss_next   = clr ? '0 : sat_inc(loss_reg, loss_inc);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= HUNT;
      pos_reg     <= '0;
      good_reg    <= '0;
      miss_reg    <= '0;
      pid_hi_reg  <= '0;
      pid_lo_reg  <= '0;
      filt_reg    <= '0;
      hist_reg    <= 1'b0;
      dup_reg     <= 1'b0;
      last_cc_reg <= '0;
      cc_err_reg  <= 1'b0;
      pkt_reg     <= '0;
      err_reg     <= '0;
      loss_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      pos_reg     <= pos_next;
      good_reg    <= good_next;
      miss_reg    <= miss_next;
      pid_hi_reg  <= pid_hi_next;
      pid_lo_reg  <= pid_lo_next;
      filt_reg    <= pid_filter;
      hist_reg    <= hist_next;
      dup_reg     <= dup_next;
      last_cc_reg <= last_cc_next;
      cc_err_reg  <= cc_err_next;
      pkt_reg     <= pkt_next;
      err_reg     <= err_next;
      loss_reg    <= loss_next;
    end
  end

  assign locked        = (state_reg == LOCKED);
  assign cc_err        = cc_err_reg;
  assign pkt_cnt       = pkt_reg;
  assign cc_err_cnt    = err_reg;
  assign sync_loss_cnt = loss_reg;

endmodule

// File: rtl/ts_cc_monitor.sv
// Multi-channel TS continuity monitor: NUM_CH independent ts_ch_monitor
// instances, each fed from its own slice of the packed input buses.
// Ports: clk, reset_n (sync, active low), byte_data[8c+7:8c], byte_valid[c],
// pid_filter[13c+12:13c], clr; outputs locked[c], cc_err[c] and the
// per-channel CNT_W-bit counters pkt_cnt, cc_err_cnt, sync_loss_cnt.
module ts_cc_monitor #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter int LOCK_N   = 3,
  parameter int UNLOCK_N = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH*8-1:0]     byte_data,
  input  logic [NUM_CH-1:0]       byte_valid,
  input  logic [NUM_CH*13-1:0]    pid_filter,
  input  logic                    clr,
  output logic [NUM_CH-1:0]       locked,
  output logic [NUM_CH-1:0]       cc_err,
  output logic [NUM_CH*CNT_W-1:0] pkt_cnt,
  output logic [NUM_CH*CNT_W-1:0] cc_err_cnt,
  output logic [NUM_CH*CNT_W-1:0] sync_loss_cnt
);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      ts_ch_monitor #(
        .CNT_W   (CNT_W),
        .LOCK_N  (LOCK_N),
        .UNLOCK_N(UNLOCK_N)
      ) u_ch (
        .clk          (clk),
        .reset_n      (reset_n),
        .byte_data    (byte_data[8*gi +: 8]),
        .byte_valid   (byte_valid[gi]),
        .pid_filter   (pid_filter[13*gi +: 13]),
        .clr          (clr),
        .locked       (locked[gi]),
        .cc_err       (cc_err[gi]),
        .pkt_cnt      (pkt_cnt[CNT_W*gi +: CNT_W]),
        .cc_err_cnt   (cc_err_cnt[CNT_W*gi +: CNT_W]),
        .sync_loss_cnt(sync_loss_cnt[CNT_W*gi +: CNT_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_ts_cc_monitor.sv
// Directed bench for ts_cc_monitor. A 4-channel 16-bit-counter instance is
// the main target; a 1-channel 4-bit-counter instance mirrors channel 0's
// byte stream (with its own clr) to exercise counter saturation.
module tb_ts_cc_monitor;
  import ts_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clr = 1'b0;
  logic        clr_s = 1'b0;
  logic [31:0] byte_data = '0;
  logic [3:0]  byte_valid = '0;
  logic [51:0] pid_filter = '0;
  logic [3:0]  locked, cc_err;
  logic [63:0] pkt_cnt, cc_err_cnt, sync_loss_cnt;
  logic        locked_s, cc_err_s;
  logic [3:0]  pkt_cnt_s, cc_err_cnt_s, sync_loss_cnt_s;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses[4] = '{0, 0, 0, 0};
  int pulses_s = 0;
  int err_cyc[4], rise_cyc[4], fall_cyc[4], sync_cyc[4], hdr_cyc[4];
  logic [3:0] lock_q = '0;
  int p0, p1, p2, p3, ps;

  ts_cc_monitor #(.NUM_CH(4), .CNT_W(16), .LOCK_N(3), .UNLOCK_N(3)) dut (
    .clk(clk), .reset_n(reset_n), .byte_data(byte_data), .byte_valid(byte_valid),
    .pid_filter(pid_filter), .clr(clr), .locked(locked), .cc_err(cc_err),
    .pkt_cnt(pkt_cnt), .cc_err_cnt(cc_err_cnt), .sync_loss_cnt(sync_loss_cnt)
  );

  ts_cc_monitor #(.NUM_CH(1), .CNT_W(4), .LOCK_N(3), .UNLOCK_N(3)) dut_s (
    .clk(clk), .reset_n(reset_n), .byte_data(byte_data[7:0]), .byte_valid(byte_valid[0]),
    .pid_filter(pid_filter[12:0]), .clr(clr_s), .locked(locked_s), .cc_err(cc_err_s),
    .pkt_cnt(pkt_cnt_s), .cc_err_cnt(cc_err_cnt_s), .sync_loss_cnt(sync_loss_cnt_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder: pulse counts and the cycle of each output transition.
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (cc_err[c] === 1'b1) begin
        pulses[c]  = pulses[c] + 1;
        err_cyc[c] = cyc;
      end
      if (locked[c] === 1'b1 && lock_q[c] !== 1'b1) rise_cyc[c] = cyc;
      if (locked[c] === 1'b0 && lock_q[c] === 1'b1) fall_cyc[c] = cyc;
    end
    if (cc_err_s === 1'b1) pulses_s = pulses_s + 1;
    lock_q = locked;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pkt_byte(input int i, input logic [7:0] sync,
                                          input logic [12:0] pid, input logic [1:0] afc,
                                          input logic [3:0] cc);
    case (i)
      0:       return sync;
      1:       return {3'b000, pid[12:8]};
      2:       return pid[7:0];
      3:       return {2'b00, afc, cc};
      default: return 8'h00;
    endcase
  endfunction

  // One packet on each channel in mask; channel c uses PID pid+c and CC ccs[4c+3:4c].
  task automatic send(input logic [3:0] mask, input logic [3:0] gap, input logic [7:0] sync,
                      input logic [12:0] pid, input logic [1:0] afc, input logic [15:0] ccs,
                      input int len, input bit clr_s_hdr);
    int idx[4];
    for (int c = 0; c < 4; c++) idx[c] = mask[c] ? 0 : len;
    while (idx[0] < len || idx[1] < len || idx[2] < len || idx[3] < len) begin
      clr_s = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (idx[c] < len && (!gap[c] || $urandom_range(0, 3) != 0)) begin
          byte_valid[c] = 1'b1;
          byte_data[8*c +: 8] = pkt_byte(idx[c], sync, pid + 13'(c), afc, ccs[4*c +: 4]);
          if (idx[c] == 0) sync_cyc[c] = cyc;
          if (idx[c] == 3) begin
            hdr_cyc[c] = cyc;
            if (c == 0 && clr_s_hdr) clr_s = 1'b1;
          end
          idx[c]++;
        end else begin
          byte_valid[c] = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    byte_valid = '0;
    clr_s = 1'b0;
  endtask

  task automatic pkt0(input logic [7:0] sync, input logic [1:0] afc, input logic [3:0] cc);
    send(4'b0001, 4'b0000, sync, 13'h100, afc, {12'h000, cc}, PKT_LEN, 1'b0);
  endtask

  task automatic do_clr();
    clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
  endtask

  initial begin
    pid_filter = {13'h103, 13'h102, 13'h101, 13'h100};
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", 64'(locked), 0);
    check("rst_cc_err", 64'(cc_err), 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_cc_err_cnt", cc_err_cnt, 0);
    check("rst_sync_loss", sync_loss_cnt, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Acquisition: 5 clean packets, CC 0..4
    pkt0(SYNC_BYTE, 2'b01, 4'd0);
    pkt0(SYNC_BYTE, 2'b01, 4'd1);
    check("acq_not_locked_p2", 64'(locked[0]), 0);
    pkt0(SYNC_BYTE, 2'b01, 4'd2);
    check("acq_lock_cycle", 64'(rise_cyc[0]), 64'(sync_cyc[0] + 1));
    pkt0(SYNC_BYTE, 2'b01, 4'd3);
    pkt0(SYNC_BYTE, 2'b01, 4'd4);
    check("acq_locked", 64'(locked), 64'h1);
    check("acq_pkt_cnt", 64'(pkt_cnt[15:0]), 3);
    check("acq_cc_err_cnt", 64'(cc_err_cnt[15:0]), 0);
    check("acq_no_pulse", 64'(pulses[0]), 0);

    // CC skip 0,1,3
    do_clr();
    check("clr_pkt_cnt", 64'(pkt_cnt[15:0]), 0);
    check("clr_keeps_lock", 64'(locked[0]), 1);
    p0 = pulses[0];
    pkt0(SYNC_BYTE, 2'b01, 4'd0);
    pkt0(SYNC_BYTE, 2'b01, 4'd1);
    pkt0(SYNC_BYTE, 2'b01, 4'd3);
    check("skip_cc_err_cnt", 64'(cc_err_cnt[15:0]), 1);
    check("skip_pulse_count", 64'(pulses[0] - p0), 1);
    check("skip_pulse_cycle", 64'(err_cyc[0]), 64'(hdr_cyc[0] + 1));
    check("skip_pkt_cnt", 64'(pkt_cnt[15:0]), 3);

    // Duplicates, AFC without payload, null PID, filter change
    do_clr();
    pkt0(SYNC_BYTE, 2'b01, 4'd5);
    pkt0(SYNC_BYTE, 2'b01, 4'd5);
    pkt0(SYNC_BYTE, 2'b01, 4'd6);
    check("dup_once_ok", 64'(cc_err_cnt[15:0]), 0);
    do_clr();
    pkt0(SYNC_BYTE, 2'b01, 4'd5);
    pkt0(SYNC_BYTE, 2'b01, 4'd5);
    pkt0(SYNC_BYTE, 2'b01, 4'd5);
    check("dup_twice_err", 64'(cc_err_cnt[15:0]), 1);
    pkt0(SYNC_BYTE, 2'b10, 4'd5);
    check("afc10_same_ok", 64'(cc_err_cnt[15:0]), 1);
    pkt0(SYNC_BYTE, 2'b00, 4'd6);
    check("afc00_change_err", 64'(cc_err_cnt[15:0]), 2);
    pid_filter[12:0] = 13'h1FFF;
    send(4'b0001, 4'b0000, SYNC_BYTE, 13'h1FFF, 2'b01, 16'h0003, PKT_LEN, 1'b0);
    send(4'b0001, 4'b0000, SYNC_BYTE, 13'h1FFF, 2'b01, 16'h0009, PKT_LEN, 1'b0);
    check("null_pid_ignored", 64'(cc_err_cnt[15:0]), 2);
    pid_filter[12:0] = 13'h100;
    pkt0(SYNC_BYTE, 2'b01, 4'd0);
    check("filter_change_store", 64'(cc_err_cnt[15:0]), 2);
    pkt0(SYNC_BYTE, 2'b01, 4'd2);
    check("filter_after_err", 64'(cc_err_cnt[15:0]), 3);
    check("filter_pkt_cnt", 64'(pkt_cnt[15:0]), 9);

    // Sync loss and reacquisition
    pkt0(8'h00, 2'b01, 4'd3);
    pkt0(8'h00, 2'b01, 4'd4);
    check("loss_still_locked", 64'(locked[0]), 1);
    pkt0(8'h00, 2'b01, 4'd5);
    check("loss_unlocked", 64'(locked[0]), 0);
    check("loss_fall_cycle", 64'(fall_cyc[0]), 64'(sync_cyc[0] + 1));
    check("loss_sync_loss_cnt", 64'(sync_loss_cnt[15:0]), 1);
    check("loss_pkt_cnt", 64'(pkt_cnt[15:0]), 11);
    p0 = pulses[0];
    pkt0(SYNC_BYTE, 2'b01, 4'd7);
    pkt0(SYNC_BYTE, 2'b01, 4'd8);
    pkt0(SYNC_BYTE, 2'b01, 4'd9);
    check("relock_locked", 64'(locked[0]), 1);
    check("relock_no_pulse", 64'(pulses[0] - p0), 0);
    check("relock_cc_err_cnt", 64'(cc_err_cnt[15:0]), 3);
    check("relock_pkt_cnt", 64'(pkt_cnt[15:0]), 12);

    // All channels with valid gaps; only channel 2 skips a CC
    p0 = pulses[0]; p1 = pulses[1]; p2 = pulses[2]; p3 = pulses[3];
    send(4'hF, 4'hF, SYNC_BYTE, 13'h100, 2'b01, 16'h000A, PKT_LEN, 1'b0);
    send(4'hF, 4'hF, SYNC_BYTE, 13'h100, 2'b01, 16'h111B, PKT_LEN, 1'b0);
    send(4'hF, 4'hF, SYNC_BYTE, 13'h100, 2'b01, 16'h222C, PKT_LEN, 1'b0);
    send(4'hF, 4'hF, SYNC_BYTE, 13'h100, 2'b01, 16'h333D, PKT_LEN, 1'b0);
    send(4'hF, 4'hF, SYNC_BYTE, 13'h100, 2'b01, 16'h454E, PKT_LEN, 1'b0);
    check("multi_locked", 64'(locked), 64'hF);
    check("multi_pulse_ch0", 64'(pulses[0] - p0), 0);
    check("multi_pulse_ch1", 64'(pulses[1] - p1), 0);
    check("multi_pulse_ch2", 64'(pulses[2] - p2), 1);
    check("multi_pulse_ch3", 64'(pulses[3] - p3), 0);
    check("multi_pulse_cycle_ch2", 64'(err_cyc[2]), 64'(hdr_cyc[2] + 1));
    check("multi_cc_err_cnt", cc_err_cnt, 64'h0000_0001_0000_0003);
    check("multi_pkt_cnt", pkt_cnt, 64'h0003_0003_0003_0011);
    check("multi_sync_loss", sync_loss_cnt, 64'h0000_0000_0000_0001);

    // Saturation on the 4-bit instance, then clr against a coincident error
    clr_s = 1'b1; @(posedge clk); #1; clr_s = 1'b0;
    ps = pulses_s;
    for (int k = 0; k < 16; k++) pkt0(SYNC_BYTE, 2'b00, 4'(k & 1));
    check("sat_reach_15", 64'(cc_err_cnt_s), 15);
    pkt0(SYNC_BYTE, 2'b00, 4'd0);
    check("sat_hold_15", 64'(cc_err_cnt_s), 15);
    send(4'b0001, 4'b0000, SYNC_BYTE, 13'h100, 2'b00, 16'h0001, PKT_LEN, 1'b1);
    check("sat_clr_wins", 64'(cc_err_cnt_s), 0);
    check("sat_pulse_count", 64'(pulses_s - ps), 17);
    check("sat_pkt_cnt_clr", 64'(pkt_cnt_s), 0);
    check("sat_loss_clr", 64'(sync_loss_cnt_s), 0);
    check("sat_locked", 64'(locked_s), 1);
    check("sat_main_cc_err_cnt", 64'(cc_err_cnt[15:0]), 21);

    // Reset in the middle of a packet, then reacquire
    send(4'b0001, 4'b0000, SYNC_BYTE, 13'h100, 2'b01, 16'h0002, 100, 1'b0);
    reset_n = 1'b0; @(posedge clk); #1; reset_n = 1'b1;
    check("midrst_locked", 64'(locked), 0);
    check("midrst_pkt_cnt", pkt_cnt, 0);
    check("midrst_cc_err_cnt", cc_err_cnt, 0);
    check("midrst_small_cnt", 64'(cc_err_cnt_s), 0);
    pkt0(SYNC_BYTE, 2'b01, 4'd0);
    pkt0(SYNC_BYTE, 2'b01, 4'd1);
    pkt0(SYNC_BYTE, 2'b01, 4'd2);
    check("midrst_relock", 64'(locked[0]), 1);
    check("midrst_lock_cycle", 64'(rise_cyc[0]), 64'(sync_cyc[0] + 1));
    check("midrst_pkt_after", 64'(pkt_cnt[15:0]), 1);
    check("midrst_err_after", 64'(cc_err_cnt[15:0]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ts_cc_monitor.md
TS_CC_MONITOR -- requirements
Module: ts_cc_monitor

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent TS byte channels.
REQ-002 Parameter CNT_W, default 16, width of every statistics counter.
REQ-003 Parameter LOCK_N, default 3, consecutive good sync bytes needed to lock.
REQ-004 Parameter UNLOCK_N, default 3, consecutive bad sync bytes needed to drop lock.
REQ-005 clk  in  1  single system clock.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 byte_data  in  NUM_CH*8  channel c byte on bits [8c+7:8c].
REQ-008 byte_valid  in  NUM_CH  per-channel byte qualifier.
REQ-009 pid_filter  in  NUM_CH*13  PID monitored for continuity on each channel.
REQ-010 clr  in  1  synchronous clear of all counters; lock state is kept.
REQ-011 locked  out  NUM_CH  per-channel sync lock status.
REQ-012 cc_err  out  NUM_CH  one-cycle continuity-error pulse.
REQ-013 pkt_cnt, cc_err_cnt, sync_loss_cnt  out  NUM_CH*CNT_W each  per-channel counters.

Function
REQ-014 Each channel SHALL run independently; it advances only on cycles with its byte_valid high.
REQ-015 Each channel SHALL hold a byte position counter 0..187 that wraps 187->0.
REQ-016 Per-channel FSM states SHALL be HUNT, CONFIRM and LOCKED.
REQ-017 In HUNT, byte 0x47 -> CONFIRM with position 1 and good-count 1; any other byte stays in HUNT.
REQ-018 In CONFIRM, at position 0: byte 0x47 increments good-count and moves to LOCKED when good-count reaches LOCK_N; any other byte -> HUNT.
REQ-019 In LOCKED, a position-0 byte other than 0x47 increments a miss count, and 0x47 zeroes it.
REQ-020 When the miss count reaches UNLOCK_N, the FSM SHALL go to HUNT, increment sync_loss_cnt and clear CC history.
REQ-021 locked SHALL be high exactly while the FSM is in LOCKED.
REQ-022 In LOCKED, header fields SHALL be taken as follows: byte1[4:0]=PID[12:8], byte2=PID[7:0], byte3[5:4]=AFC, byte3[3:0]=CC.
REQ-023 pkt_cnt SHALL increment on every position-3 byte while LOCKED.
REQ-024 The CC check SHALL run on a position-3 byte only when PID==pid_filter and PID!=0x1FFF.
REQ-025 The first checked packet after reset, clr or unlock SHALL only store CC and SHALL NOT flag an error.
REQ-026 For AFC 01 or 11: CC==last+1 mod 16 is good; CC==last is a permitted duplicate once; a second consecutive duplicate, or any other value, is an error.
REQ-027 For AFC 00 or 10: CC!=last is an error.
REQ-028 Stored last-CC SHALL update to the received CC on every checked packet, including erroneous ones.
REQ-029 cc_err SHALL pulse, and cc_err_cnt increment, in the cycle after the position-3 byte is accepted (latency 1).
REQ-030 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-031 If clr coincides with an increment, clr SHALL win and the counter SHALL read 0.
REQ-032 A pid_filter change SHALL clear CC history for that channel.

Reset
REQ-033 On reset_n low at a clk edge, the following SHALL clear: all FSMs to HUNT, positions, good/miss counts and CC history.
REQ-034 Reset SHALL drive locked, cc_err and all counters to 0.
REQ-035 Reset asserted mid-packet SHALL abandon the packet; reacquisition SHALL start from HUNT.

Structure
REQ-036 Sync byte 0x47, packet length 188, null PID 0x1FFF and the FSM state enum SHALL live in shared package ts_pkg.
REQ-037 Per-channel logic SHALL be a sub-module ts_ch_monitor, instantiated NUM_CH times by generate.
REQ-038 The top level SHALL contain only instantiation and bus slicing.

Verification
REQ-039 Channel 0 gets 5 clean packets, PID 0x100, CC 0..4, pid_filter=0x100 -> locked rises at the third sync byte; pkt_cnt=3 (post-lock packets 3..5); cc_err_cnt=0.
REQ-040 CC sequence 0,1,3 on the monitored PID -> one cc_err pulse one cycle after the packet-3 header byte; cc_err_cnt=1.
REQ-041 CC sequence 5,5,6 gives 0 errors; sequence 5,5,5 gives 1 error.
REQ-042 Corrupt 3 consecutive sync bytes while locked -> locked falls at the third; sync_loss_cnt=1; the next 3 clean packets relock with no cc_err.
REQ-043 All 4 channels are driven with independent valid gaps, and only channel 2 carries a CC skip -> only cc_err[2] pulses; the other channels' counters are unaffected.
REQ-044 Force cc_err_cnt to saturation at CNT_W=4 (15 errors plus 1 more) -> the count holds at 15; clr in the same cycle as an error -> 0.
